// File: rtl/x_uart_pkg.sv
// Shared definitions for the UART calibration command receiver.
// Holds the command byte values and the state encodings used by the
// byte deserialiser and the command decoder.
package x_uart_pkg;

    localparam logic [7:0] CMD_SET_CTRL = 8'h43;
    localparam logic [7:0] CMD_TRIGGER  = 8'h54;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    typedef enum logic {
        D_CMD = 1'b0,
        D_ARG = 1'b1
    } dec_state_t;

endpackage

// File: rtl/x_uart_rx_byte.sv
// 8N1 byte deserialiser: two-flop input synchroniser followed by a
// start/data/stop state machine timed by a reloaded bit-period counter.
// Emits a one-cycle byte_vld with the byte on a good stop bit, or a
// one-cycle frame_err when the stop bit samples low.
module x_uart_rx_byte
    import x_uart_pkg::*;
#(
    parameter int P_CLKS = 104
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_vld,
    output logic       o_frame_err
);

    localparam int CNT_W = $clog2(P_CLKS) + 1;
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(P_CLKS - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(P_CLKS / 2 - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             rxPrev_q;
    rx_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bitIdx_q;
    logic [7:0]       shift_q;
    logic [7:0]       byte_q;
    logic             byteVld_q;
    logic             frameErr_q;

    // Synchronise the line, then walk start/data/stop sampling mid-bit; the start
    // check halfway through the start bit rejects short low glitches, and IDLE
    // only arms on a falling edge so a held-low break never starts a new frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rxPrev_q   <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            byteVld_q  <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            sync1_q    <= i_uart_rx;
            sync2_q    <= sync1_q;
            rxPrev_q   <= sync2_q;
            byteVld_q  <= 1'b0;
            frameErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!sync2_q && rxPrev_q) begin
                        state_q <= START;
                        cnt_q   <= HALF_RELOAD;
                    end
                end
                START: begin
                    if (cnt_q == '0) begin
                        if (sync2_q) begin
                            state_q <= IDLE;
                        end else begin
                            state_q  <= DATA;
                            cnt_q    <= FULL_RELOAD;
                            bitIdx_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {sync2_q, shift_q[7:1]};
                        cnt_q   <= FULL_RELOAD;
                        if (bitIdx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bitIdx_q <= bitIdx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == '0) begin
                        if (sync2_q) begin
                            byte_q    <= shift_q;
                            byteVld_q <= 1'b1;
                        end else begin
                            frameErr_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_byte      = byte_q;
    assign o_byte_vld  = byteVld_q;
    assign o_frame_err = frameErr_q;

endmodule

// File: rtl/x_uart_cmd_rx.sv
// Host-to-FPGA calibration command receiver. Decodes 'C' <tap> to update the
// delay-line tap index and 'T' to fire a capture pulse.
// Optional feature: define X_UART_CMD_RX_TIMEOUT_EN to abandon a pending 'C'
// when its argument byte does not arrive within p_timeout bit periods.
module x_uart_cmd_rx
    import x_uart_pkg::*;
#(
    parameter int p_clk_hz  = 12000000,
    parameter int p_baud    = 115200,
    parameter int p_timeout = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_ctrl,
    output logic       o_ctrl_vld,
    output logic       o_capture,
    output logic       o_frame_err
);

    localparam int P_CLKS = p_clk_hz / p_baud;
    localparam int TO_CYC = p_timeout * P_CLKS;

    logic [7:0] rxByte;
    logic       rxByteVld;
    logic       rxFrameErr;

    dec_state_t decState_q;
    logic [7:0] ctrl_q;
    logic       ctrlVld_q;
    logic       capture_q;
    logic       frameErr_q;

    x_uart_rx_byte #(
        .P_CLKS(P_CLKS)
    ) u_rx_byte (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_uart_rx  (i_uart_rx),
        .o_byte     (rxByte),
        .o_byte_vld (rxByteVld),
        .o_frame_err(rxFrameErr)
    );

`ifdef X_UART_CMD_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC) + 1;
    localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TO_CYC - 1);
    logic [TO_W-1:0] toCnt_q;
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = ^TO_CYC;
`endif

    // Command decoder: a received byte in D_ARG always becomes the tap index,
    // so command values are legal arguments; a framing error drops a pending SET.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            decState_q <= D_CMD;
            ctrl_q     <= '0;
            ctrlVld_q  <= 1'b0;
            capture_q  <= 1'b0;
            frameErr_q <= 1'b0;
`ifdef X_UART_CMD_RX_TIMEOUT_EN
            toCnt_q    <= '0;
`endif
        end else begin
            ctrlVld_q  <= 1'b0;
            capture_q  <= 1'b0;
            frameErr_q <= rxFrameErr;
            case (decState_q)
                D_CMD: begin
                    if (rxByteVld) begin
                        if (rxByte == CMD_SET_CTRL) begin
                            decState_q <= D_ARG;
`ifdef X_UART_CMD_RX_TIMEOUT_EN
                            toCnt_q    <= TO_RELOAD;
`endif
                        end else if (rxByte == CMD_TRIGGER) begin
                            capture_q <= 1'b1;
                        end
                    end
                end
                D_ARG: begin
                    if (rxByteVld) begin
                        ctrl_q     <= rxByte;
                        ctrlVld_q  <= 1'b1;
                        decState_q <= D_CMD;
                    end else if (rxFrameErr) begin
                        decState_q <= D_CMD;
`ifdef X_UART_CMD_RX_TIMEOUT_EN
                    end else if (toCnt_q == '0) begin
                        decState_q <= D_CMD;
                    end else begin
                        toCnt_q <= toCnt_q - 1'b1;
`endif
                    end
                end
                default: decState_q <= D_CMD;
            endcase
        end
    end

    assign o_ctrl      = ctrl_q;
    assign o_ctrl_vld  = ctrlVld_q;
    assign o_capture   = capture_q;
    assign o_frame_err = frameErr_q;

endmodule
